// File: rtl/fetch_stage.sv
// Instruction-fetch front end.
// Owns the program counter and keeps at most one instruction-memory request
// outstanding. It presents {instruction, pc, valid} to the fetch/decode
// pipeline register. While downstream is stalled it can park one response in
// a hold slot. After a redirect it discards the response to the squashed
// request.
module fetch_stage #(
    parameter int                      DATA_WIDTH   = 32,
    parameter int                      ADDRESS_BITS = 32,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0,
    parameter logic [DATA_WIDTH-1:0]   NOP          = 32'h00000013
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               stall,
    input  logic                               flush,
    input  logic [ADDRESS_BITS-1:0]            target_pc,
    output logic                               i_mem_read,
    output logic [ADDRESS_BITS-1:0]            i_mem_address,
    input  logic                               i_mem_ready,
    input  logic                               i_mem_valid,
    input  logic [DATA_WIDTH-1:0]              i_mem_data,
    output logic                               fetch_valid,
    output logic [DATA_WIDTH-1:0]              fetch_instruction,
    output logic [ADDRESS_BITS-1:0]            fetch_pc,
    output logic [DATA_WIDTH+ADDRESS_BITS:0]   flush_bundle
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state, next_state;
    logic [ADDRESS_BITS-1:0] pc;
    logic [ADDRESS_BITS-1:0] req_pc;
    logic                    pending;
    logic                    drop;
    logic                    hold_valid;
    logic [DATA_WIDTH-1:0]   hold_instr;
    logic [ADDRESS_BITS-1:0] hold_pc;

    logic resp;
    logic accept;
    logic capture;

    // A response only counts if this stage is actually waiting for one.
    // Stray i_mem_valid pulses, such as a late reply after a reset, are ignored.
    assign resp = i_mem_valid && pending;

    // A new request may go out in the same cycle the previous response returns.
    // This gives one fetch per cycle against a 1-cycle memory.
    assign i_mem_read    = (state == RUN) && !flush && !stall && !hold_valid
                           && (!pending || resp);
    assign i_mem_address = pc;
    assign accept        = i_mem_read && i_mem_ready;

    // Park a live response when downstream cannot take it this cycle.
    assign capture = !flush && !hold_valid && resp && !drop && stall;

    assign flush_bundle = {1'b0, {ADDRESS_BITS{1'b0}}, NOP};

    // Next-state logic: leave IDLE on start; RUN is left only by reset.
    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        if (state == IDLE && start)
            next_state = RUN;
    end

    // Output select: flush squashes, then held data, then bypassed response.
    always_comb begin
        fetch_valid       = 1'b0;
        fetch_instruction = NOP;
        fetch_pc          = '0;
        if (flush) begin
            fetch_valid = 1'b0;
        end else if (hold_valid) begin
            fetch_valid       = 1'b1;
            fetch_instruction = hold_instr;
            fetch_pc          = hold_pc;
        end else if (resp && !drop) begin
            fetch_valid       = 1'b1;
            fetch_instruction = i_mem_data;
            fetch_pc          = req_pc;
        end
    end

    // Control state: FSM, PC, the outstanding-request flags and hold occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state      <= IDLE;
            pc         <= RESET_PC;
            req_pc     <= '0;
            pending    <= 1'b0;
            drop       <= 1'b0;
            hold_valid <= 1'b0;
        end else begin
            state <= next_state;
            if (flush) begin
                // A response that arrives with the flush is dropped here.
                // A request still in flight is marked for discard when it returns.
                pc         <= target_pc;
                hold_valid <= 1'b0;
                drop       <= pending && !resp;
                if (resp)
                    pending <= 1'b0;
            end else begin
                if (accept) begin
                    req_pc  <= pc;
                    pc      <= pc + ADDRESS_BITS'(4);
                    pending <= 1'b1;
                end else if (resp) begin
                    pending <= 1'b0;
                end
                if (resp && drop)
                    drop <= 1'b0;
                if (hold_valid && !stall)
                    hold_valid <= 1'b0;
                else if (capture)
                    hold_valid <= 1'b1;
            end
        end
    end

    // Hold payload register, qualified by hold_valid.
    always_ff @(posedge clock) begin
        // NOTE: payload is left unreset; hold_valid alone says whether it is meaningful.
        if (capture) begin
            hold_instr <= i_mem_data;
            hold_pc    <= req_pc;
        end
    end

endmodule
